// File: rtl/count_capture.sv
// count_capture: timestamps rising edges of evt_in by sampling the shared
// free-running counter into a small first-word-fall-through FIFO. It also
// raises single-cycle pulses on compare match and on counter wrap-around.
// All outputs come straight from registers.

module count_capture #(
    parameter int l     = 4,    // counter / compare / capture width
    parameter int DEPTH = 4     // FIFO depth, power of two, >= 2
) (
    input  logic                         clk,
    input  logic                         rst,        // synchronous, active low
    input  logic [l-1:0]                 count_in,
    input  logic                         evt_in,
    input  logic [l-1:0]                 cmp_val,
    input  logic                         cmp_en,
    input  logic                         cap_ready,
    input  logic                         ovf_clr,
    output logic [l-1:0]                 cap_data,
    output logic                         cap_valid,
    output logic [$clog2(DEPTH+1)-1:0]   cap_level,
    output logic                         cap_ovf,
    output logic                         cmp_match,
    output logic                         wrap
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1'b1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

    // Storage and bookkeeping state
    logic [l-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic [l-1:0]  data_q,   data_d;
    logic          valid_q,  valid_d;
    logic          ovf_q,    ovf_d;

    // Edge / compare / wrap history
    logic          evt_q;
    logic [l-1:0]  prev_count_q;
    logic          prev_match_q, prev_match_d;
    logic          match_q,      match_d;
    logic          wrap_q,       wrap_d;

    // Per-cycle decisions
    logic          rise_s;
    logic          pop_s;
    logic          full_s;
    logic          push_s;
    logic          drop_s;

    // Next-state logic for the FIFO, the sticky overflow flag and the pulses
    always_comb begin
        rise_s   = evt_in & ~evt_q;
        pop_s    = valid_q & cap_ready;
        full_s   = (level_q == FULL_LVL);
        // A full FIFO still accepts a sample when the head leaves this cycle.
        push_s   = rise_s & (~full_s | pop_s);
        drop_s   = rise_s & full_s & ~pop_s;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        valid_d = (level_d != {LW{1'b0}});

        // Pre-compute the head that will be visible next cycle. The slot being
        // written this cycle is not in mem_q yet, so forward count_in when the
        // new head is exactly that slot (push into empty, or push+pop at level 1).
        if (level_d == {LW{1'b0}}) begin
            data_d = {l{1'b0}};
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            data_d = count_in;
        end else begin
            data_d = mem_q[rd_ptr_d];
        end

        // A new drop beats a simultaneous clear.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        prev_match_d = cmp_en & (count_in == cmp_val);
        match_d      = prev_match_d & ~prev_match_q;
        wrap_d       = (prev_count_q == {l{1'b1}}) & (count_in == {l{1'b0}});
    end

    // Sample storage: written at the tail on every accepted capture
    always_ff @(posedge clk) begin
        if (push_s && rst) begin
            mem_q[wr_ptr_q] <= count_in;
        end
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            level_q      <= {LW{1'b0}};
            data_q       <= {l{1'b0}};
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
            evt_q        <= 1'b0;
            prev_count_q <= {l{1'b0}};
            prev_match_q <= 1'b0;
            match_q      <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
            evt_q        <= evt_in;
            prev_count_q <= count_in;
            prev_match_q <= prev_match_d;
            match_q      <= match_d;
            wrap_q       <= wrap_d;
        end
    end

    assign cap_data  = data_q;
    assign cap_valid = valid_q;
    assign cap_level = level_q;
    assign cap_ovf   = ovf_q;
    assign cmp_match = match_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_count_capture.sv
// Testbench for count_capture: a directed vector table, a few hand-written
// multi-cycle sequences, then randomized stimulus against a queue-based model.

module tb_count_capture;

    localparam int L     = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [L-1:0] count_in;
    logic         evt_in;
    logic [L-1:0] cmp_val;
    logic         cmp_en;
    logic         cap_ready;
    logic         ovf_clr;
    logic [L-1:0] cap_data;
    logic         cap_valid;
    logic [2:0]   cap_level;
    logic         cap_ovf;
    logic         cmp_match;
    logic         wrap;

    int checks = 0;
    int errors = 0;

    count_capture #(.l(L), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .evt_in    (evt_in),
        .cmp_val   (cmp_val),
        .cmp_en    (cmp_en),
        .cap_ready (cap_ready),
        .ovf_clr   (ovf_clr),
        .cap_data  (cap_data),
        .cap_valid (cap_valid),
        .cap_level (cap_level),
        .cap_ovf   (cap_ovf),
        .cmp_match (cmp_match),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (queue of timestamps) ----------------
    int mq[$];
    bit m_ovf, m_pevt, m_peq, m_match, m_wrap;
    int m_pcnt;

    task automatic model_step(input int r, c, e, cv, ce, rd, clr);
        bit rise, pop, drop, eq;
        if (r == 0) begin
            mq.delete();
            m_ovf = 0; m_pevt = 0; m_peq = 0; m_pcnt = 0;
            m_match = 0; m_wrap = 0;
        end else begin
            rise = (e != 0) && !m_pevt;
            pop  = (mq.size() > 0) && (rd != 0);
            drop = rise && (mq.size() == DEPTH) && !pop;
            if (pop) void'(mq.pop_front());
            if (rise && !drop) mq.push_back(c);
            if (drop) m_ovf = 1;
            else if (clr != 0) m_ovf = 0;
            eq      = (ce != 0) && (c == cv);
            m_match = eq && !m_peq;
            m_peq   = eq;
            m_wrap  = (m_pcnt == 15) && (c == 0);
            m_pcnt  = c;
            m_pevt  = (e != 0);
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle.
    task automatic cycle(input int r, c, e, cv, ce, rd, clr);
        rst = r[0]; count_in = c[3:0]; evt_in = e[0]; cmp_val = cv[3:0];
        cmp_en = ce[0]; cap_ready = rd[0]; ovf_clr = clr[0];
        @(posedge clk);
        model_step(r, c, e, cv, ce, rd, clr);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic chk_model(input int idx);
        chk("m_data",  idx, int'(cap_data),  (mq.size() > 0) ? mq[0] : 0);
        chk("m_valid", idx, int'(cap_valid), (mq.size() > 0) ? 1 : 0);
        chk("m_level", idx, int'(cap_level), mq.size());
        chk("m_ovf",   idx, int'(cap_ovf),   int'(m_ovf));
        chk("m_match", idx, int'(cmp_match), int'(m_match));
        chk("m_wrap",  idx, int'(wrap),      int'(m_wrap));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int r, c, e, cv, ce, rd, clr;
        int d, v, lv, ov, m, w;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int r, c, e, cv, ce, rd, clr, d, v, lv, ov, m, w);
        vec_t t;
        t.r = r; t.c = c; t.e = e; t.cv = cv; t.ce = ce; t.rd = rd; t.clr = clr;
        t.d = d; t.v = v; t.lv = lv; t.ov = ov; t.m = m; t.w = w;
        tbl.push_back(t);
    endtask

    initial begin
        int pulses;
        rst = 1'b0; count_in = '0; evt_in = 1'b0; cmp_val = '0;
        cmp_en = 1'b0; cap_ready = 1'b0; ovf_clr = 1'b0;

        //  r  c  e cv ce rd clr |  d  v lv ov  m  w
        add(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);  // reset
        add(1, 4, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        add(1, 5, 1, 0, 0, 0, 0,    5, 1, 1, 0, 0, 0);  // capture 5
        add(1, 6, 0, 0, 0, 1, 0,    0, 0, 0, 0, 0, 0);  // pop it
        add(1, 3, 1, 0, 0, 0, 0,    3, 1, 1, 0, 0, 0);  // held high from 3
        add(1, 4, 1, 0, 0, 0, 0,    3, 1, 1, 0, 0, 0);
        add(1, 5, 1, 0, 0, 0, 0,    3, 1, 1, 0, 0, 0);
        add(1, 6, 1, 0, 0, 0, 0,    3, 1, 1, 0, 0, 0);
        add(1, 7, 1, 0, 0, 0, 0,    3, 1, 1, 0, 0, 0);
        add(1, 8, 1, 0, 0, 0, 0,    3, 1, 1, 0, 0, 0);
        add(1, 9, 0, 0, 0, 1, 0,    0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);  // fill: 1,3,5,7,9
        add(1, 1, 1, 0, 0, 0, 0,    1, 1, 1, 0, 0, 0);
        add(1, 2, 0, 0, 0, 0, 0,    1, 1, 1, 0, 0, 0);
        add(1, 3, 1, 0, 0, 0, 0,    1, 1, 2, 0, 0, 0);
        add(1, 4, 0, 0, 0, 0, 0,    1, 1, 2, 0, 0, 0);
        add(1, 5, 1, 0, 0, 0, 0,    1, 1, 3, 0, 0, 0);
        add(1, 6, 0, 0, 0, 0, 0,    1, 1, 3, 0, 0, 0);
        add(1, 7, 1, 0, 0, 0, 0,    1, 1, 4, 0, 0, 0);
        add(1, 8, 0, 0, 0, 0, 0,    1, 1, 4, 0, 0, 0);
        add(1, 9, 1, 0, 0, 0, 0,    1, 1, 4, 1, 0, 0);  // 9 dropped
        add(1,10, 0, 0, 0, 0, 0,    1, 1, 4, 1, 0, 0);
        add(1,11, 1, 0, 0, 1, 0,    3, 1, 4, 1, 0, 0);  // full: pop 1, push 11
        add(1,12, 0, 0, 0, 1, 0,    5, 1, 3, 1, 0, 0);
        add(1,13, 0, 0, 0, 1, 0,    7, 1, 2, 1, 0, 0);
        add(1,14, 0, 0, 0, 1, 0,   11, 1, 1, 1, 0, 0);
        add(1,15, 0, 0, 0, 1, 0,    0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 1);  // wrap 15->0
        add(1, 1, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0);  // ovf_clr
        add(1, 2, 1, 0, 0, 0, 0,    2, 1, 1, 0, 0, 0);  // 3 entries then reset
        add(1, 3, 0, 0, 0, 0, 0,    2, 1, 1, 0, 0, 0);
        add(1, 4, 1, 0, 0, 0, 0,    2, 1, 2, 0, 0, 0);
        add(1, 5, 0, 0, 0, 0, 0,    2, 1, 2, 0, 0, 0);
        add(1, 6, 1, 0, 0, 0, 0,    2, 1, 3, 0, 0, 0);
        add(0, 7, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);  // reset mid-queue
        add(1, 8, 1, 0, 0, 0, 0,    8, 1, 1, 0, 0, 0);  // high right after reset
        add(1, 9, 1, 0, 0, 1, 0,    0, 0, 0, 0, 0, 0);
        add(1,10, 0, 0, 0, 1, 0,    0, 0, 0, 0, 0, 0);
        add(1,11, 1, 0, 0, 1, 0,   11, 1, 1, 0, 0, 0);  // rise+ready while empty
        add(1,12, 0, 0, 0, 1, 0,    0, 0, 0, 0, 0, 0);
        add(1, 8, 0, 9, 1, 0, 0,    0, 0, 0, 0, 0, 0);  // compare
        add(1, 9, 0, 9, 1, 0, 0,    0, 0, 0, 0, 1, 0);
        add(1, 9, 0, 9, 1, 0, 0,    0, 0, 0, 0, 0, 0);  // stalled on 9
        add(1, 9, 0, 9, 1, 0, 0,    0, 0, 0, 0, 0, 0);
        add(1,10, 0, 9, 1, 0, 0,    0, 0, 0, 0, 0, 0);
        add(1, 9, 0, 9, 0, 0, 0,    0, 0, 0, 0, 0, 0);  // disabled
        add(1, 9, 0, 9, 1, 0, 0,    0, 0, 0, 0, 1, 0);  // re-enabled on 9
        add(1,10, 0, 9, 1, 0, 0,    0, 0, 0, 0, 0, 0);
        add(1, 7, 0, 9, 1, 0, 0,    0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 9, 1, 0, 0,    0, 0, 0, 0, 0, 0);  // 7->0: no wrap
        add(1,15, 0, 9, 1, 0, 0,    0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 9, 1, 0, 0,    0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 9, 1, 0, 0,    0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].c, tbl[i].e, tbl[i].cv, tbl[i].ce, tbl[i].rd, tbl[i].clr);
            chk("t_data",  i, int'(cap_data),  tbl[i].d);
            chk("t_valid", i, int'(cap_valid), tbl[i].v);
            chk("t_level", i, int'(cap_level), tbl[i].lv);
            chk("t_ovf",   i, int'(cap_ovf),   tbl[i].ov);
            chk("t_match", i, int'(cmp_match), tbl[i].m);
            chk("t_wrap",  i, int'(wrap),      tbl[i].w);
        end

        // Free-running counter: one compare pulse per lap, none when disabled.
        pulses = 0;
        for (int i = 0; i < 48; i++) begin
            cycle(1, i % 16, 0, 9, 1, 0, 0);
            chk_model(1000 + i);
            if (cmp_match) pulses++;
        end
        chk("match_pulses_en", 0, pulses, 3);
        pulses = 0;
        for (int i = 0; i < 48; i++) begin
            cycle(1, i % 16, 0, 9, 0, 0, 0);
            chk_model(2000 + i);
            if (cmp_match) pulses++;
        end
        chk("match_pulses_dis", 0, pulses, 0);

        // Drop coinciding with ovf_clr: set wins; a later clear then clears.
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(1, 2 * k + 1, 1, 0, 0, 0, 0);
            cycle(1, 2 * k + 2, 0, 0, 0, 0, 0);
        end
        cycle(1, 9, 1, 0, 0, 0, 1);
        chk("ovf_set_wins", 0, int'(cap_ovf), 1);
        chk_model(3000);
        cycle(1, 10, 0, 0, 0, 0, 1);
        chk("ovf_cleared", 0, int'(cap_ovf), 0);
        chk_model(3001);

        // Randomized traffic against the model.
        begin
            int c;
            c = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 9) < 8) c = (c + 1) % 16;
                else c = $urandom_range(0, 15);
                cycle(($urandom_range(0, 99) == 0) ? 0 : 1, c,
                      $urandom_range(0, 1), $urandom_range(0, 15),
                      ($urandom_range(0, 3) != 0) ? 1 : 0,
                      ($urandom_range(0, 2) == 0) ? 1 : 0,
                      ($urandom_range(0, 15) == 0) ? 1 : 0);
                chk_model(10000 + i);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_capture.md
Name: count_capture

Overview:
- Downstream consumer of the n-bit free-running counter.
- Samples the counter value on rising edges of an event input and queues the samples in a small first-word-fall-through FIFO, which is drained through a valid/ready handshake.
- Also flags a programmable compare match and counter wrap-around, each as a single-cycle pulse.
- Used for timestamping events and generating compare interrupts from the shared counter.

Parameters:
- l, 4, width of count_in, cmp_val and cap_data; must match the upstream counter width.
- DEPTH, 4, capture FIFO depth in entries; power of 2, at least 2.

Ports:
- clk  input  1  clock; the upstream counter runs on the same clock.
- rst  input  1  synchronous, active-low reset.
- count_in  input  l  current counter value.
- evt_in  input  1  capture event, already synchronous to clk; rising edge triggers a capture.
- cmp_val  input  l  compare value.
- cmp_en  input  1  compare enable.
- cap_ready  input  1  consumer ready.
- ovf_clr  input  1  clears cap_ovf.
- cap_data  output  l  FIFO head value.
- cap_valid  output  1  FIFO not empty.
- cap_level  output  $clog2(DEPTH+1)  number of entries held.
- cap_ovf  output  1  sticky flag: a capture was dropped.
- cmp_match  output  1  single-cycle compare pulse.
- wrap  output  1  single-cycle wrap-around pulse.

Behaviour:
- Reset: rst sampled low at a clk edge synchronously sets:
  - FIFO empty, cap_valid=0, cap_level=0, cap_data=0;
  - cap_ovf=0, cmp_match=0, wrap=0;
  - evt_d=0, prev_count=0, prev_match=0.
  Reset overrides every other input in that cycle. Reset asserted mid-operation discards queued entries.
- Edge detect: rise = evt_in & ~evt_d, with evt_d registered every cycle. Because evt_d resets to 0, evt_in already high on the first cycle after reset counts as a rising edge.
- Capture:
  - On a rise cycle, the count_in value present in that same cycle is written at the tail.
  - The entry is visible on cap_data/cap_valid on the next cycle (latency 1).
  - Only one capture per rising edge; a held-high evt_in does not recapture.
- Read:
  - cap_data always shows the head entry; it is 0 when empty.
  - Pop occurs on any cycle with cap_valid & cap_ready.
  - cap_ready while empty has no effect.
- FIFO bookkeeping:
  - cap_level is updated registered: +1 push only, -1 pop only, unchanged for push and pop together.
  - Pointers wrap modulo DEPTH.
- Full:
  - rise with cap_level==DEPTH and no pop in the same cycle: the sample is dropped, FIFO contents are unchanged, and cap_ovf is set the next cycle.
  - rise while full with a simultaneous pop: both are accepted and cap_level stays at DEPTH.
- Empty: rise with a simultaneous cap_ready while empty pushes only, because cap_valid=0 in that cycle.
- cap_ovf:
  - Sticky; cleared by ovf_clr.
  - If ovf_clr coincides with a new drop, set wins.
- Compare:
  - eq = cmp_en & (count_in==cmp_val).
  - cmp_match is registered as eq & ~prev_match, with prev_match <= eq.
  - Result: one pulse per entry into equality, 1 cycle after count_in equals cmp_val. A counter stalled on cmp_val gives a single pulse.
  - cmp_en low forces eq=0.
- Wrap:
  - wrap is registered as (prev_count == all-ones) & (count_in == 0), with prev_count <= count_in every cycle.
  - Pulses 1 cycle after count_in goes to 0.
  - A counter reset from a non-max value does not pulse wrap.
- Widths: all comparisons are exact l-bit. There is no arithmetic on count_in.

Test Plan:
- Counter enabled at 0, incrementing every cycle, l=4; evt_in pulses high 1 cycle when count_in=5 -> cap_valid rises next cycle, cap_data=5, cap_level=1; cap_ready=1 pops it and cap_level returns to 0.
- evt_in held high for 6 cycles starting at count_in=3 -> exactly one entry, value 3.
- cap_ready=0; 5 single-cycle events at counts 1,3,5,7,9 (DEPTH=4) -> cap_level=4, entries 1,3,5,7 in order, event 9 dropped, cap_ovf=1; draining yields 1,3,5,7. Then ovf_clr -> cap_ovf=0.
- FIFO full, event at count 11 with cap_ready=1 in the same cycle -> head 1 popped, 11 stored at tail, cap_level stays 4, cap_ovf unchanged.
- cmp_en=1, cmp_val=9, counter free-running -> cmp_match pulses once per 16 cycles, on the cycle after count_in=9. cmp_en=0 -> no pulses. Counter held with count_in=9 -> one pulse only.
- Counter runs 14,15,0 -> wrap pulses on the cycle after count_in=0. Counter reset from 7 to 0 -> no wrap. rst low mid-queue with 3 entries -> cap_valid=0, cap_level=0, all flags 0 on the next cycle.
